op_encoder_tx: RTL
==================

// Module: op_encoder_tx
// PURPOSE
//  Monitor-to-host direction of the NeXT sound/keyboard link, the counterpart of the host op decoder.
//  Collects reply sources (power-on reply, keyboard data, microphone samples) and arbitrates between them.
//  Builds a 24-bit op frame {opcode[7:0], payload[15:0]} and serialises it MSB first with start/stop bits.
//  Sits between the keyboard/mic front ends and the link output pin driver.
// PARAMETERS
//  CLK_PER_BIT    4  clocks per serial bit (>=2)
//  STOP_BITS      1  idle-high bits after the last data bit (>=1)
//  MIC_FIFO_LOG2  1  log2 of mic sample FIFO depth (depth 2 at default)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high
//  pwr_reply_req  in   1   pulse: queue one power-on reply (sticky until sent)
//  kbd_valid      in   1   keyboard word offered
//  kbd_data       in   16  keyboard payload
//  kbd_ready      out  1   high when keyboard slot empty; transfer = valid & ready
//  mic_enable     in   1   level: mic recording active (from mic_start/mic_stop)
//  mic_valid      in   1   mic sample offered
//  mic_sample     in   16  mic payload
//  mic_ready      out  1   high when FIFO not full, or when mic_enable=0
//  mic_overflow   out  1   sticky: mic_valid while enabled and FIFO full
//  tx_out         out  1   serial line, idle high
//  busy           out  1   high from frame load to end of last stop bit
//  frame_done     out  1   1-cycle pulse on final cycle of stop period
// BEHAVIOUR
//  Reset values: tx_out=1, busy=0, frame_done=0, mic_overflow=0, kbd_ready=1, mic_ready=1.
//  Reset clears FIFO, kbd slot, pwr flag, and state. Reset mid-frame: tx_out=1 on the first cycle after reset is sampled.
//  Frame codes: PWR = 24'hC5EF00; KBD = {8'hC6, kbd_data}; MIC = {8'hC7, mic_sample}.
//  Accept rules:
//   - kbd: one-entry slot.
//   - mic: FIFO with DEPTH = 2**MIC_FIFO_LOG2, accepted only while mic_enable=1.
//     With mic_enable=0, mic_valid is acked (ready=1) and the sample is discarded.
//     Samples already queued are still sent after mic_enable falls.
//   - mic_overflow sets when mic_valid & mic_enable & full; the sample is dropped.
//  FSM states IDLE, START, DATA, STOP:
//   - IDLE: if any source is pending, latch its frame into a 24-bit shift register and go to START next cycle.
//     Priority: PWR > KBD > MIC. Load happens on the same edge that frees the source (kbd_ready/FIFO pop).
//   - START: tx_out=0 for CLK_PER_BIT cycles -> DATA.
//   - DATA: tx_out=shift[23], shift left every CLK_PER_BIT cycles. After 24 bits -> STOP.
//   - STOP: tx_out=1 for STOP_BITS*CLK_PER_BIT cycles. frame_done pulses on the last cycle -> IDLE.
//  Timing:
//   - Back-to-back frames: IDLE occupies exactly one cycle between frames.
//   - Frame length = (25+STOP_BITS)*CLK_PER_BIT+1 cycles, counted from the first IDLE cycle with a request.
//   - busy=1 in START/DATA/STOP.
//  Simultaneous events:
//   - A source accepted in the same cycle as an IDLE arbitration is not seen until the next IDLE.
//   - Push and pop on a full FIFO in the same cycle: pop takes effect first, so the push succeeds and sets no overflow.
//   - A pwr_reply_req arriving while a PWR frame is in flight re-arms the flag, so one more reply is sent.
//  Width rules: bit counter 5 bits (0..23); baud counter sized $clog2(CLK_PER_BIT*STOP_BITS); FIFO pointers wrap modulo DEPTH.
// TESTING (CLK_PER_BIT=4, STOP_BITS=1, depth 2)
//  1. Reset, pwr_reply_req pulse -> tx_out: 4 clk low, then bits of C5EF00 MSB first, 4 clk/bit, then 4 clk high.
//     frame_done at cycle 105 after the request.
//  2. kbd 16'h1234 and pwr in the same cycle -> C5EF00 sent first, then C61234. Exactly 1 idle cycle between frames.
//  3. mic_enable=1, push 3 samples back to back while the line is busy ->
//     third push stalls (mic_ready=0). If forced valid anyway: mic_overflow=1 and that sample is lost.
//  4. mic_enable=0, mic_valid with 16'hBEEF -> mic_ready=1, no frame sent. Queued samples from before the disable still go out.
//  5. Assert reset at bit 10 of a KBD frame -> tx_out=1 the next cycle, busy=0, kbd_ready=1, no frame_done.
//  6. Saturate all sources for 20 frames -> no MIC frame while KBD/PWR pending.
//     Every frame decodes correctly with a reference deserialiser.

Source files
------------

// File: rtl/op_encoder_tx_if.sv
// Link between the reply sources (keyboard, mic, power-on) and the op encoder,
// plus the encoder's serial line and status outputs.
interface op_encoder_tx_if;
    logic        pwr_reply_req;
    logic        kbd_valid;
    logic [15:0] kbd_data;
    logic        kbd_ready;
    logic        mic_enable;
    logic        mic_valid;
    logic [15:0] mic_sample;
    logic        mic_ready;
    logic        mic_overflow;
    logic        tx_out;
    logic        busy;
    logic        frame_done;

    modport master (
        output pwr_reply_req, kbd_valid, kbd_data, mic_enable, mic_valid, mic_sample,
        input  kbd_ready, mic_ready, mic_overflow, tx_out, busy, frame_done
    );

    modport slave (
        input  pwr_reply_req, kbd_valid, kbd_data, mic_enable, mic_valid, mic_sample,
        output kbd_ready, mic_ready, mic_overflow, tx_out, busy, frame_done
    );
endinterface

// File: rtl/op_encoder_tx.sv
// Monitor-to-host op encoder: arbitrates power-on, keyboard and mic replies and
// serialises a 24-bit {opcode, payload} frame MSB first with start/stop bits.
module op_encoder_tx #(
    parameter int CLK_PER_BIT   = 4,
    parameter int STOP_BITS     = 1,
    parameter int MIC_FIFO_LOG2 = 1
) (
    input  logic             clk,
    input  logic             reset,
    op_encoder_tx_if.slave   link
);
    localparam int DEPTH = 2 ** MIC_FIFO_LOG2;
    localparam int PW    = (MIC_FIFO_LOG2 > 0) ? MIC_FIFO_LOG2 : 1;
    localparam int CW    = MIC_FIFO_LOG2 + 1;
    localparam int BW    = $clog2(CLK_PER_BIT * STOP_BITS);

    localparam logic [BW-1:0] BAUD_BIT  = BW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_STOP = BW'(CLK_PER_BIT * STOP_BITS - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [23:0]   shift_q, shift_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [4:0]    bit_q, bit_d;
    logic          pwr_q, pwr_d;
    logic          kbd_full_q, kbd_full_d;
    logic [15:0]   kbd_data_q, kbd_data_d;
    logic [15:0]   mic_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic in_idle, fifo_empty, fifo_full;
    logic load_pwr, load_kbd, load_mic;
    logic kbd_acc, mic_push, mic_drop;

    assign in_idle    = (state_q == S_IDLE);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULL);

    assign load_pwr = in_idle & pwr_q;
    assign load_kbd = in_idle & ~pwr_q & kbd_full_q;
    assign load_mic = in_idle & ~pwr_q & ~kbd_full_q & ~fifo_empty;

    assign kbd_acc  = link.kbd_valid & ~kbd_full_q;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign mic_push = link.mic_valid & link.mic_enable & (~fifo_full | load_mic);
    assign mic_drop = link.mic_valid & link.mic_enable & fifo_full & ~load_mic;

    assign link.kbd_ready    = ~kbd_full_q;
    assign link.mic_ready    = ~link.mic_enable | ~fifo_full | load_mic;
    assign link.mic_overflow = ovf_q;
    assign link.busy         = ~in_idle;
    assign link.frame_done   = (state_q == S_STOP) && (baud_q == '0);
    assign link.tx_out       = (state_q == S_START) ? 1'b0 :
                               (state_q == S_DATA)  ? shift_q[23] : 1'b1;

    always_comb begin
        pwr_d      = link.pwr_reply_req | (pwr_q & ~load_pwr);
        kbd_full_d = kbd_acc | (kbd_full_q & ~load_kbd);
        kbd_data_d = kbd_acc ? link.kbd_data : kbd_data_q;
        ovf_d      = ovf_q | mic_drop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (mic_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
        if (load_mic) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
        case ({mic_push, load_mic})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                if (load_pwr | load_kbd | load_mic) begin
                    shift_d = load_pwr ? 24'hC5EF00 :
                              load_kbd ? {8'hC6, kbd_data_q} :
                                         {8'hC7, mic_mem_q[rd_ptr_q]};
                    baud_d  = BAUD_BIT;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_q == '0) begin
                    state_d = S_DATA;
                    baud_d  = BAUD_BIT;
                    bit_d   = 5'd23;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            S_DATA: begin
                if (baud_q == '0) begin
                    if (bit_q == 5'd0) begin
                        state_d = S_STOP;
                        baud_d  = BAUD_STOP;
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                        bit_d   = bit_q - 5'd1;
                        baud_d  = BAUD_BIT;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: begin
                if (baud_q == '0) state_d = S_IDLE;
                else              baud_d  = baud_q - BW'(1);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            pwr_q      <= 1'b0;
            kbd_full_q <= 1'b0;
            kbd_data_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            pwr_q      <= pwr_d;
            kbd_full_q <= kbd_full_d;
            kbd_data_q <= kbd_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Sample storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (mic_push) mic_mem_q[wr_ptr_q] <= link.mic_sample;
    end
endmodule
